sha2_w_expander_iter: RTL and testbench

Iterative, parameterised SHA-2 message-schedule generator. It accepts one 16-word padded block and streams the schedule words W_0 … W_(N-1), one per cycle, over a valid/ready handshake.

- Supports SHA-256 (32-bit words) and SHA-512 (64-bit words).
- A 16-word sliding window replaces the per-round unrolled schedule stages, so one instance feeds a round-iterative compression core.
- The optional early-stop build truncates the schedule for the double-SHA-256 tail.

---
 rtl/sha2_w_expander_iter.sv | 125 ++++++++++++
 tb/tb_sha2_w_expander_iter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_w_expander_iter.sv
// SHA-256/512 message-schedule generator: 16-word sliding window, one W_t per cycle (SHA2_W_EARLY_STOP_EN truncates at STOP_ROUND).
// Latency: block accepted at edge k presents W_0 in cycle k+1; one idle cycle between blocks.
// Backpressure: w_ready=0 freezes window, index and outputs; blk_ready is low for the whole run.
module sha2_w_expander_iter #(
  parameter int WORD_W     = 32,
  parameter int ROUNDS     = 64,
  parameter int STOP_ROUND = 57
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] block_in,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_out,
  output logic [6:0]           w_idx,
  output logic                 busy,
  output logic                 done
);

`ifdef SHA2_W_EARLY_STOP_EN
  localparam int LAST = STOP_ROUND;
`else
  localparam int LAST = ROUNDS;
`endif
  localparam logic [6:0] LAST_IDX = 7'(LAST - 1);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_w_expander_iter: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 128) begin : g_bad_rounds
      $error("sha2_w_expander_iter: ROUNDS must be 16..128");
    end
`ifdef SHA2_W_EARLY_STOP_EN
    if (STOP_ROUND < 16 || STOP_ROUND > ROUNDS) begin : g_bad_stop
      $error("sha2_w_expander_iter: STOP_ROUND must be 16..ROUNDS");
    end
`endif
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] window [16];
  logic [6:0]        t;
  logic              load;
  logic              fire;
  logic              fire_last;
  logic [WORD_W-1:0] w_new;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // window[0] is W_t, so window[15] receives W_(t+16) from W_(t+14), W_(t+9), W_(t+1), W_t
  assign w_new     = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
  assign fire      = (state == RUN) && w_ready;
  assign fire_last = fire && (t == LAST_IDX);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (blk_valid) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (fire_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) window[i] <= '0;
      t    <= '0;
      done <= 1'b0;
    end else begin
      done <= fire_last;
      if (load) begin
        for (int i = 0; i < 16; i++) window[i] <= block_in[16*WORD_W-1 - i*WORD_W -: WORD_W];
        t <= '0;
      end else if (fire) begin
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= w_new;
        t          <= t + 7'd1;
      end
    end
  end

  assign blk_ready = (state == IDLE);
  assign w_valid   = (state == RUN);
  assign busy      = (state == RUN);
  assign w_out     = window[0];
  assign w_idx     = t;

  // The index presented with a valid word never runs past the final round.
  a_idx_range: assert property (@(posedge CLK) disable iff (!RST) w_valid |-> (w_idx <= LAST_IDX));

endmodule

// File: tb/tb_sha2_w_expander_iter.sv
// Scoreboard bench: driver pushes reference schedule words, monitor pops and compares on each handshake.
module tb_sha2_w_expander_iter;

`ifdef SHA2_W_EARLY_STOP_EN
  localparam int LAST32 = 57;
`else
  localparam int LAST32 = 64;
`endif
  localparam int LAST64 = 80;

  typedef struct {
    logic [63:0] w;
    int          idx;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sel;
  logic          bv;
  logic          wr;
  logic [511:0]  blk32;
  logic [1023:0] blk64;

  logic        br32, wv32, busy32, done32;
  logic [31:0] wo32;
  logic [6:0]  idx32;
  logic        br64, wv64, busy64, done64;
  logic [63:0] wo64;
  logic [6:0]  idx64;
  logic        bv32, bv64;

  assign bv32 = bv && !sel;
  assign bv64 = bv && sel;

  sha2_w_expander_iter #(.WORD_W(32), .ROUNDS(64), .STOP_ROUND(57)) dut32 (
    .CLK(clk), .RST(rst_n), .blk_valid(bv32), .blk_ready(br32), .block_in(blk32),
    .w_valid(wv32), .w_ready(wr), .w_out(wo32), .w_idx(idx32), .busy(busy32), .done(done32)
  );

  sha2_w_expander_iter #(.WORD_W(64), .ROUNDS(80), .STOP_ROUND(80)) dut64 (
    .CLK(clk), .RST(rst_n), .blk_valid(bv64), .blk_ready(br64), .block_in(blk64),
    .w_valid(wv64), .w_ready(wr), .w_out(wo64), .w_idx(idx64), .busy(busy64), .done(done64)
  );

  logic        m_bv, m_br, m_wv, m_busy, m_done;
  logic [63:0] m_wo;
  logic [6:0]  m_idx;
  assign m_bv   = sel ? bv64   : bv32;
  assign m_br   = sel ? br64   : br32;
  assign m_wv   = sel ? wv64   : wv32;
  assign m_busy = sel ? busy64 : busy32;
  assign m_done = sel ? done64 : done32;
  assign m_wo   = sel ? wo64   : {32'h0, wo32};
  assign m_idx  = sel ? idx64  : idx32;

  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          rmode = 0;
  exp_t        q[$];
  logic [63:0] obs [128];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference schedule, computed directly from the recurrence on a flat array.
  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input int ww);
    logic [63:0] m;
    m = (ww == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    x = x & m;
    return ((x >> n) | (x << (ww - n))) & m;
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input int ww);
    if (ww == 32) return ror(x, 7, ww) ^ ror(x, 18, ww) ^ (x >> 3);
    return ror(x, 1, ww) ^ ror(x, 8, ww) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input int ww);
    if (ww == 32) return ror(x, 17, ww) ^ ror(x, 19, ww) ^ (x >> 10);
    return ror(x, 19, ww) ^ ror(x, 61, ww) ^ (x >> 6);
  endfunction

  task automatic send(input logic [63:0] wds [16]);
    logic [63:0] w [80];
    logic [63:0] mask;
    int ww, n, k;
    ww   = sel ? 64 : 32;
    n    = sel ? LAST64 : LAST32;
    mask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < 16; i++) w[i] = wds[i] & mask;
    for (int i = 16; i < n; i++)
      w[i] = (s1(w[i-2], ww) + w[i-7] + s0(w[i-15], ww) + w[i-16]) & mask;
    for (int i = 0; i < n; i++) q.push_back('{w[i], i, (i == n - 1)});
    for (int i = 0; i < 16; i++) begin
      if (sel) blk64[1023 - 64*i -: 64] = wds[i];
      else     blk32[511 - 32*i -: 32]  = wds[i][31:0];
    end
    bv = 1'b1;
    k  = 0;
    do begin @(negedge clk); k++; end while (!m_br && k < 2000);
    if (!m_br) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=blk_ready_low required=accept_within_2000");
    end
    @(posedge clk); #1;
    bv = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((q.size() != 0 || m_wv) && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) begin
      checks++; errors++;
      $display("FAIL %s drain_timeout actual=%0d_pending required=0", name, q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic make_abc(output logic [63:0] wds [16]);
    for (int i = 0; i < 16; i++) wds[i] = '0;
    wds[0]  = 64'h61626380;
    wds[15] = 64'h18;
  endtask

  task automatic make_rand(output logic [63:0] wds [16]);
    for (int i = 0; i < 16; i++) wds[i] = {$urandom(), $urandom()};
  endtask

  // w_ready driver: steady or pseudo-random, changed just after each edge
  initial begin
    wr = 1'b1;
    forever begin
      @(posedge clk); #1;
      wr = (rmode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops expectations on handshakes and checks done/latency/stall rules.
  bit          exp_done = 0, exp_done_nxt, exp_start = 0, prev_stall = 0;
  logic [63:0] prev_wo;
  logic [6:0]  prev_idx;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done = 0; exp_start = 0; prev_stall = 0;
    end else begin
      exp_done_nxt = 0;
      chk("done", m_done, exp_done);
      if (exp_done) chk("blk_ready_after_done", m_br, 1);
      if (exp_start) begin
        chk("first_valid", m_wv, 1);
        chk("first_idx", m_idx, 0);
      end
      if (prev_stall) begin
        chk("stall_w_out", m_wo, prev_wo);
        chk("stall_w_idx", m_idx, prev_idx);
      end
      if (m_wv) begin
        chk("blk_ready_in_run", m_br, 0);
        chk("busy_in_run", m_busy, 1);
      end
      if (m_wv && wr) begin
        hs_cnt++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=idx%0d required=none", m_idx);
        end else begin
          e = q.pop_front();
          chk("w_out", m_wo, e.w);
          chk("w_idx", m_idx, e.idx);
          obs[m_idx] = m_wo;
          exp_done_nxt = e.last;
        end
      end
      if (m_done) done_cnt++;
      exp_start  = m_bv && m_br;
      prev_stall = m_wv && !wr;
      prev_wo    = m_wo;
      prev_idx   = m_idx;
      exp_done   = exp_done_nxt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wds [16];
    int k;
    rst_n = 1'b1; sel = 1'b0; bv = 1'b0; blk32 = '0; blk64 = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_blk_ready32", br32, 1);  chk("rst_w_valid32", wv32, 0);
    chk("rst_w_out32", wo32, 0);      chk("rst_w_idx32", idx32, 0);
    chk("rst_busy32", busy32, 0);     chk("rst_done32", done32, 0);
    chk("rst_blk_ready64", br64, 1);  chk("rst_w_out64", wo64, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // SHA-256 "abc", free-running consumer
    hs_cnt = 0; done_cnt = 0;
    make_abc(wds); send(wds); wait_drain("abc");
    chk("abc_w16", obs[16], 64'h61626380);
    chk("abc_w17", obs[17], 64'h000F0000);
    chk("abc_hs_count", hs_cnt, LAST32);
    chk("abc_done_count", done_cnt, 1);

    // same block under random backpressure
    rmode = 1; hs_cnt = 0; done_cnt = 0;
    make_abc(wds); send(wds); wait_drain("backpressure");
    chk("bp_hs_count", hs_cnt, LAST32);
    chk("bp_done_count", done_cnt, 1);

    // two random blocks back to back, blk_valid held high across them
    rmode = 0; hs_cnt = 0; done_cnt = 0;
    make_rand(wds); send(wds);
    make_rand(wds); send(wds); wait_drain("b2b");
    chk("b2b_hs_count", hs_cnt, 2 * LAST32);
    chk("b2b_done_count", done_cnt, 2);

    // SHA-512: W_0=1, rest zero; then a random block with backpressure
    sel = 1'b1; hs_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) wds[i] = '0;
    wds[0] = 64'h1;
    send(wds); wait_drain("sha512");
    chk("s512_w16", obs[16], 64'h1);
    chk("s512_w17", obs[17], 64'h0);
    chk("s512_w18", obs[18], 64'h0000200000000008);
    chk("s512_hs_count", hs_cnt, LAST64);
    chk("s512_done_count", done_cnt, 1);
    rmode = 1; hs_cnt = 0;
    make_rand(wds); send(wds); wait_drain("sha512_rand");
    chk("s512r_hs_count", hs_cnt, LAST64);
    rmode = 0; sel = 1'b0;
    @(posedge clk); #1;

    // reset asserted while idx 30 is on the bus
    hs_cnt = 0; done_cnt = 0;
    make_abc(wds); send(wds);
    k = 0;
    do begin @(negedge clk); k++; end while (!(wv32 && idx32 == 7'd30) && k < 500);
    if (k >= 500) begin
      checks++; errors++;
      $display("FAIL idx30_timeout actual=not_seen required=idx30");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_blk_ready", br32, 1); chk("mid_rst_w_valid", wv32, 0);
    chk("mid_rst_w_out", wo32, 0);     chk("mid_rst_w_idx", idx32, 0);
    chk("mid_rst_busy", busy32, 0);    chk("mid_rst_done", done32, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    @(posedge clk); #1;
    hs_cnt = 0; done_cnt = 0;
    make_abc(wds); send(wds); wait_drain("after_reset");
    chk("post_rst_hs_count", hs_cnt, LAST32);
    chk("post_rst_done_count", done_cnt, 1);
    chk("post_rst_w17", obs[17], 64'h000F0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
